// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the eight-way memory arbiter
package mem_arbiter_pkg;

  localparam int NUM_REQ     = 8;
  localparam int SEL_W       = 3;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational rotating priority encoder, search starts just after last
module rr_pick8
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               valid
);

  logic [SEL_W-1:0] cand;

  // walk offsets from farthest to nearest so the nearest set bit after last wins
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = last + SEL_W'(i);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter8.sv
// rtl/mem_arbiter8.sv - round-robin arbiter sequencing one memory port for eight requesters
module mem_arbiter8
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned timeout = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] write,
  input  logic               mem_resp,
  output logic [SEL_W-1:0]   sel,
  output logic               mem_read,
  output logic               mem_write,
  output logic [NUM_REQ-1:0] done,
  output logic               error,
  output logic               busy
);

  // counter value on the last ACCESS cycle allowed before aborting
  localparam logic [15:0] cnt_last = 16'(timeout - 1);

  state_t           state;
  logic [SEL_W-1:0] last;
  logic             wr_q;
  logic [15:0]      cnt;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;

  rr_pick8 u_pick (
    .req   (req),
    .last  (last),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // transaction sequencer: grant, hold the strobe until response or timeout, pulse completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      last      <= 3'd7;
      wr_q      <= 1'b0;
      cnt       <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      done      <= '0;
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done  <= '0;
          error <= 1'b0;
          if (pick_valid) begin
            sel       <= pick_idx;
            last      <= pick_idx;
            wr_q      <= write[pick_idx];
            cnt       <= '0;
            mem_read  <= !write[pick_idx];
            mem_write <= write[pick_idx];
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_resp || cnt == cnt_last) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= 8'd1 << sel;
            error     <= !mem_resp;
            state     <= DONE;
          end else begin
            cnt       <= cnt + 16'd1;
            mem_read  <= !wr_q;
            mem_write <= wr_q;
          end
        end
        DONE: begin
          done  <= '0;
          error <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          done      <= '0;
          error     <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter8.sv
// tb/tb_mem_arbiter8.sv - self-checking bench for mem_arbiter8 against a round-robin reference model
module tb_mem_arbiter8;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] write = 8'h00;
  logic       mem_resp = 1'b0;
  logic [2:0] sel;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] done;
  logic       error;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int last_m = 7;

  mem_arbiter8 #(.timeout(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .write     (write),
    .mem_resp  (mem_resp),
    .sel       (sel),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .done      (done),
    .error     (error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // first requester found scanning upward from the one after the previous winner
  function automatic int pick(input logic [7:0] r, input int prev);
    for (int off = 1; off <= 8; off++) begin
      if (r[(prev + off) % 8]) return (prev + off) % 8;
    end
    return -1;
  endfunction

  // called at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE cycle
  task automatic txn(input logic [7:0] r, input logic [7:0] w, input int d, input bit drop);
    int  exp_i;
    bit  exp_wr;
    bit  exp_err;
    int  n;
    req = r;
    write = w;
    mem_resp = 1'b0;
    if (r == 8'h00) begin
      mem_resp = 1'b1;
      @(negedge clk);
      mem_resp = 1'b0;
      chk("idle_busy", {15'd0, busy}, 16'd0);
      chk("idle_rd", {15'd0, mem_read}, 16'd0);
      chk("idle_done", {8'd0, done}, 16'd0);
      return;
    end
    exp_i = pick(r, last_m);
    last_m = exp_i;
    exp_wr = w[exp_i];
    exp_err = (d > TMO);
    n = exp_err ? TMO : d;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk("acc_sel", {13'd0, sel}, 16'(exp_i));
      chk("acc_rd", {15'd0, mem_read}, {15'd0, !exp_wr});
      chk("acc_wr", {15'd0, mem_write}, {15'd0, exp_wr});
      chk("acc_busy", {15'd0, busy}, 16'd1);
      chk("acc_done", {8'd0, done}, 16'd0);
      if (drop) req = r & ~(8'd1 << exp_i);
      write = ~w;
      mem_resp = (k == d);
    end
    @(negedge clk);
    mem_resp = 1'b0;
    chk("done_vec", {8'd0, done}, 16'd1 << exp_i);
    chk("done_err", {15'd0, error}, {15'd0, exp_err});
    chk("done_rd", {15'd0, mem_read}, 16'd0);
    chk("done_wr", {15'd0, mem_write}, 16'd0);
    chk("done_busy", {15'd0, busy}, 16'd1);
    chk("done_sel", {13'd0, sel}, 16'(exp_i));
    req = r;
    write = w;
    @(negedge clk);
    chk("post_busy", {15'd0, busy}, 16'd0);
    chk("post_done", {8'd0, done}, 16'd0);
    chk("post_err", {15'd0, error}, 16'd0);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_sel", {13'd0, sel}, 16'd0);
    chk("rst_rd", {15'd0, mem_read}, 16'd0);
    chk("rst_wr", {15'd0, mem_write}, 16'd0);
    chk("rst_done", {8'd0, done}, 16'd0);
    chk("rst_err", {15'd0, error}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single read, response in the second ACCESS cycle
    txn(8'b0000_0100, 8'h00, 2, 1'b0);

    // all requesting, response immediately: 0..7 then 0, reads on even, writes on odd
    last_m = 7;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) txn(8'hFF, 8'hAA, 1, 1'b0);

    // wrap from 5 skips 6 and 7
    txn(8'b0010_0000, 8'h00, 1, 1'b0);
    txn(8'b0010_0001, 8'h00, 1, 1'b0);
    txn(8'b0010_0001, 8'h00, 1, 1'b0);

    // no response ever: abort after the timeout, then a normal transaction
    txn(8'b0000_1000, 8'h00, 1000, 1'b0);
    txn(8'b0000_1000, 8'h08, 1, 1'b0);

    // requester drops req during ACCESS, then a stray response in IDLE
    txn(8'b0000_0010, 8'h00, 3, 1'b1);
    txn(8'h00, 8'h00, 1, 1'b0);

    // reset in the middle of ACCESS for requester 6
    req = 8'h40;
    write = 8'h00;
    @(negedge clk);
    chk("mid_sel", {13'd0, sel}, 16'd6);
    chk("mid_rd", {15'd0, mem_read}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd", {15'd0, mem_read}, 16'd0);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_sel", {13'd0, sel}, 16'd0);
    chk("arst_done", {8'd0, done}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 8'h00;
    last_m = 7;
    txn(8'hC0, 8'h00, 1, 1'b0);

    // randomized traffic against the model
    for (int t = 0; t < 60; t++) begin
      logic [7:0] r;
      logic [7:0] w;
      r = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      w = 8'($urandom);
      txn(r, w, int'($urandom_range(1, TMO + 2)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter8.md
# mem_arbiter8

Round-robin arbiter sharing one memory port among eight requesters. It owns the 3-bit select that steers the shared 8-input datapath multiplexer (address and write data), and it sequences the memory read/write strobes. It also returns a one-hot completion pulse to the requester it served. It sits between the requester blocks and the single memory interface, with the select-driven multiplexer instantiated beside it.

## Interface
- timeout, 255: maximum cycles spent in ACCESS without mem_resp before the transaction is aborted; legal range 1..65535.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  per-requester request; bit i held high by requester i until its done[i].
- write  input  8  per-requester direction; bit i = 1 means write; sampled with the grant.
- mem_resp  input  1  memory completion, valid only while mem_read or mem_write is high.
- sel  output  3  index of the granted requester; drives the datapath multiplexer select.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- done  output  8  one-hot, one-cycle completion pulse to the served requester.
- error  output  1  one-cycle pulse, coincident with done, when the transaction timed out.
- busy  output  1  high in ACCESS and DONE.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, req != 0: pick the winner, register sel and the winner's write bit, clear the timeout counter, go to ACCESS. IDLE, req == 0: stay in IDLE.
- Round-robin pick: search starts at (last+1) mod 8 and wraps upward; the first set bit wins. last updates to the winner at the grant.
- ACCESS: mem_read = !wr_q, mem_write = wr_q. Both strobes are driven from registers and are never high together.
  - mem_resp = 1: go to DONE.
  - Otherwise the counter increments. When the counter equals timeout-1 and mem_resp = 0: go to DONE with the abort flag set.
- DONE: done[sel] = 1 for exactly one cycle, error = abort flag, strobes low, then go to IDLE.
- sel stays constant from the grant edge through the end of DONE.
- Changes to req or write during ACCESS/DONE are ignored; the granted transaction always completes.
- A requester that drops req before its grant is simply not selected.
- mem_resp outside ACCESS is ignored.
- Counter width is 16 bits; no wrap, because the counter resets at every grant.

## Timing
- Reset values, applied asynchronously on rst high: sel = 0, mem_read = 0, mem_write = 0, done = 0, error = 0, busy = 0, state = IDLE, last = 7. Requester 0 therefore has highest priority after reset.
- Reset mid-ACCESS drops the strobes immediately. No done pulse is issued, and the requester must re-request.
- Latency, with req seen in IDLE at cycle 0:
  - ACCESS in cycle 1.
  - mem_resp seen in cycle n ≥ 1 gives DONE in cycle n+1 and IDLE in cycle n+2.
- Minimum transaction occupancy: 3 cycles (IDLE, ACCESS, DONE). Back-to-back grants to different requesters are 3 cycles apart.
- With all 8 requesting continuously, grant order after reset is 0,1,...,7,0. No requester waits more than 7 transactions.
- Timeout abort: DONE falls timeout cycles after ACCESS entry, error = 1, and the strobes drop at the DONE edge.

## Structure
- Package mem_arbiter_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - NUM_REQ = 8 and SEL_W = 3;
  - the default timeout constant.
- Sub-module rr_pick8: a combinational rotating priority encoder. Inputs are req[7:0] and last[2:0]; outputs are idx[2:0] and valid.
- mem_arbiter8 holds the FSM, the sel/last/wr_q registers and the timeout counter.
- The datapath multiplexer is instantiated at the parent level and fed by sel.

## Test plan
- Reset, then req = 8'b0000_0100 with write[2] = 0 and mem_resp at ACCESS cycle 2 -> sel = 2, mem_read high for 2 cycles, done = 8'b0000_0100 for one cycle, error = 0, back in IDLE.
- req = 8'hFF held, write = 8'hAA, mem_resp every ACCESS cycle -> grants 0..7 then 0, every 3 cycles. mem_write high exactly for odd indices.
- After serving 5, req = 8'b0010_0001 -> grant 0 (wrap from 5 skips 6, 7). Next grant is 5.
- timeout = 4, req[3] = 1, mem_resp never asserted -> mem_read high for 4 cycles, then done[3] and error pulse together. The next request is served normally.
- rst asserted in the middle of ACCESS for requester 6 -> mem_read falls without waiting for a clock, outputs return to reset values, and a later req = 8'hC0 grants 6 (last = 7 restored).
- req[1] dropped during ACCESS, and mem_resp pulsed in IDLE -> the transaction still completes with done[1], and the stray mem_resp produces no state change.
